// File: rtl/core_execution_unit_muldiv.sv
// Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit per
// cycle on operand magnitudes, then applies the sign correction in a final cycle.
// Divide-by-zero and signed-overflow divides complete on the accepting edge.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   start_i   start request, accepted only in idle
//   kill_i    abort of the operation in flight (pipeline flush)
//   op_i      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   s1_i      rs1 (multiplicand / dividend)
//   s2_i      rs2 (multiplier / divisor)
//   result_o  registered result, valid while done_o is high
//   busy_o    high in every state except idle
//   done_o    one-cycle pulse, result valid
module core_execution_unit_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  kill_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] s1_i,
    input  logic [DATA_WIDTH-1:0] s2_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpRem    = 3'b110;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [2*W-1:0]   acc_q, acc_d;      // product, or {remainder, dividend/quotient}
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;      // negate product / quotient
    logic             rem_neg_q, rem_neg_d;
    logic [W-1:0]     result_q, result_d;

    // Operand decode on the accepting cycle
    logic           s1_signed, s2_signed, s1_neg, s2_neg;
    logic [W-1:0]   s1_mag, s2_mag;
    logic           is_div, div_zero, div_ovf;
    logic [W-1:0]   fast_result;

    always_comb begin
        s1_signed = (op_i == OpMul) || (op_i == OpMulh) || (op_i == OpMulhsu) ||
                    (op_i == OpDiv) || (op_i == OpRem);
        s2_signed = (op_i == OpMul) || (op_i == OpMulh) ||
                    (op_i == OpDiv) || (op_i == OpRem);
        s1_neg    = s1_signed && s1_i[W-1];
        s2_neg    = s2_signed && s2_i[W-1];
        s1_mag    = s1_neg ? (~s1_i + 1'b1) : s1_i;
        s2_mag    = s2_neg ? (~s2_i + 1'b1) : s2_i;
        is_div    = op_i[2];
        div_zero  = (s2_i == '0);
        div_ovf   = ((op_i == OpDiv) || (op_i == OpRem)) && (s1_i == MIN_NEG) && (s2_i == '1);
        // op_i[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            fast_result = op_i[1] ? s1_i : '1;
        end else begin
            fast_result = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration step for each algorithm
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        // Remainder shifted left with the next dividend bit brought in
        div_trial = acc_q[2*W-1:W-1];
        div_ge    = (div_trial >= {1'b0, opnd_q});
        div_diff  = div_trial[W-1:0] - opnd_q;
        div_next  = {(div_ge ? div_diff : div_trial[W-1:0]), acc_q[W-2:0], div_ge};
    end

    // Sign correction
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0]   quot_raw, rem_raw, quot_fixed, rem_fixed, fix_result;

    always_comb begin
        prod_fixed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_raw   = acc_q[W-1:0];
        rem_raw    = acc_q[2*W-1:W];
        quot_fixed = neg_q ? (~quot_raw + 1'b1) : quot_raw;
        rem_fixed  = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;
        if (op_q[2]) begin
            fix_result = op_q[1] ? rem_fixed : quot_fixed;
        end else begin
            fix_result = (op_q == OpMul) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (start_i && !kill_i) begin
                    op_d      = op_i;
                    neg_d     = s1_neg ^ s2_neg;
                    rem_neg_d = s1_neg;
                    cnt_d     = '0;
                    if (is_div && (div_zero || div_ovf)) begin
                        result_d = fast_result;
                        state_d  = StDone;
                    end else begin
                        opnd_d  = is_div ? s2_mag : s1_mag;
                        acc_d   = {{W{1'b0}}, (is_div ? s1_mag : s2_mag)};
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_result;
                state_d  = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush wins over everything in flight; the previous result stays visible
        if (kill_i && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);

endmodule

// File: tb/tb_core_execution_unit_muldiv.sv
// Self-checking bench for core_execution_unit_muldiv: a directed vector table,
// randomized operations against an arithmetic reference model, and hand-written
// kill / ignored-start / reset sequences.
module tb_core_execution_unit_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  op;
    logic [31:0] s1, s2, result;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    core_execution_unit_muldiv #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .kill_i  (kill),
        .op_i    (op),
        .s1_i    (s1),
        .s2_i    (s2),
        .result_o(result),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [63:0] q;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        return o[2] && ((b == 0) ||
               (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input bit f);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e; v.fast = f;
        return v;
    endfunction

    // Issue one operation starting at the current cycle (called #1 after an edge).
    // evt_kind at cycle evt_cyc after acceptance: 1 = stray start, 2 = kill, 3 = reset.
    // lat = cycle of done after the start cycle, -1 on timeout, -2 when aborted.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int evt_cyc, input int evt_kind,
                          output logic [31:0] got, output int lat);
        op = o; s1 = a; s2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom); s1 = $urandom; s2 = $urandom;
        lat = -1;
        got = 'x;
        for (int c = 1; c <= 60; c++) begin
            check({name, " busy"}, {31'b0, busy}, 32'd1);
            if (done) begin
                lat = c;
                got = result;
                break;
            end
            if (c == evt_cyc) begin
                case (evt_kind)
                    1: begin start = 1'b1; op = 3'b101; s1 = $urandom; s2 = $urandom | 1; end
                    2: kill = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
                @(posedge clk); #1;
                start = 1'b0; kill = 1'b0; rst = 1'b0;
                if (evt_kind == 2 || evt_kind == 3) begin
                    lat = -2;
                    return;
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            check({name, " done after"}, {31'b0, done}, 32'd0);
            check({name, " busy after"}, {31'b0, busy}, 32'd0);
        end
    endtask

    // done_o must never stay high two cycles in a row
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) check("done width", {31'b0, prev_done}, 32'd0);
        prev_done <= done;
    end

    vec_t        vecs[14];
    logic [31:0] got, a, b;
    logic [2:0]  o;
    int          lat;

    initial begin
        vecs[0]  = mk(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        vecs[1]  = mk(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        vecs[2]  = mk(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        vecs[3]  = mk(3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0);
        vecs[4]  = mk(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0);
        vecs[5]  = mk(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0);
        vecs[6]  = mk(3'd5, 32'd100,        32'd7,          32'd14,        1'b0);
        vecs[7]  = mk(3'd7, 32'd100,        32'd7,          32'd2,         1'b0);
        vecs[8]  = mk(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1);
        vecs[9]  = mk(3'd6, 32'd5,          32'd0,          32'd5,         1'b1);
        vecs[10] = mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        vecs[11] = mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        vecs[12] = mk(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);
        vecs[13] = mk(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; s1 = '0; s2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy", {31'b0, busy}, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, got, lat);
            check($sformatf("vec%0d result", i), got, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, vecs[i].fast ? 32'd1 : 32'd34);
        end

        // Kill at CALC cycle 10: previous result (vec13) stays, then restart at once
        run_op("kill", 3'd3, $urandom, $urandom, 10, 2, got, lat);
        check("kill busy", {31'b0, busy}, 32'd0);
        check("kill done", {31'b0, done}, 32'd0);
        check("kill result kept", result, 32'h8000_0000);
        run_op("after kill", 3'd5, 32'd100, 32'd7, 0, 0, got, lat);
        check("after kill result", got, 32'd14);
        check("after kill latency", lat, 32'd34);

        // Stray start during CALC is dropped
        a = $urandom; b = $urandom;
        run_op("stray start", 3'd0, a, b, 5, 1, got, lat);
        check("stray start result", got, model(3'd0, a, b));
        check("stray start latency", lat, 32'd34);

        // Reset mid-CALC
        run_op("reset mid", 3'd4, 32'd1000, 32'd3, 10, 3, got, lat);
        check("reset mid result", result, 32'd0);
        check("reset mid busy", {31'b0, busy}, 32'd0);
        check("reset mid done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), o, a, b, 0, 0, got, lat);
            check($sformatf("rand%0d op%0d 0x%08h 0x%08h result", i, o, a, b), got,
                  model(o, a, b));
            check($sformatf("rand%0d latency", i), lat, is_fast(o, a, b) ? 32'd1 : 32'd34);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
